// File: rtl/fv_req_arbiter_pkg.sv
// Shared definitions for the FV read-request arbiter: sizing constants,
// the read command sent to the FV bank controller, and the FSM state codes.
`ifndef Num_Edge_PE
`define Num_Edge_PE 4
`endif
`ifndef Max_FV_num
`define Max_FV_num 256
`endif

package fv_req_arbiter_pkg;

   localparam int NUM_EDGE_PE = `Num_Edge_PE;
   localparam int MAX_FV_NUM  = `Max_FV_num;
   localparam int FV_ADDR_W   = $clog2(MAX_FV_NUM);
   localparam int PE_TAG_W    = (NUM_EDGE_PE > 1) ? $clog2(NUM_EDGE_PE) : 1;

   // Read command towards the FV bank controller
   typedef struct packed {
      logic                 valid;
      logic [FV_ADDR_W-1:0] FV_Bank_addr;
      logic [PE_TAG_W-1:0]  PE_tag;
   } FV_MEM_CNTL2FV_Bank_CNTL;

   // Arbiter FSM states
   typedef logic [1:0] fv_state_t;
   localparam fv_state_t ST_IDLE   = 2'd0;
   localparam fv_state_t ST_ISSUE  = 2'd1;
   localparam fv_state_t ST_START  = 2'd2;
   localparam fv_state_t ST_STREAM = 2'd3;

endpackage

// File: rtl/fv_req_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last granted
// index and remembers the winner when the grant is consumed.
module rr_arbiter
   import fv_req_arbiter_pkg::*;
#(
   parameter  int NUM_PE = NUM_EDGE_PE,
   localparam int IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_PE-1:0] req_i,
   input  logic              gnt_en_i,
   output logic [NUM_PE-1:0] gnt_o,
   output logic [IDX_W-1:0]  gnt_idx_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] cand_idx;
   int               cand;

   // Scan from farthest to nearest so the PE right after ptr_q wins
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = NUM_PE; k >= 1; k--) begin
         cand     = (int'(ptr_q) + k) % NUM_PE;
         cand_idx = IDX_W'(cand);
         if (req_i[cand_idx]) begin
            gnt_o           = '0;
            gnt_o[cand_idx] = 1'b1;
            gnt_idx_o       = cand_idx;
         end
      end
   end

   // Pointer advances only when the grant is actually taken
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_en_i && (|req_i)) ptr_d = gnt_idx_o;
   end

   // Pointer starts at the last PE so PE 0 is first after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= IDX_W'(NUM_PE - 1);
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/fv_req_arbiter.sv
// FV read-request arbiter: one pending slot per Edge PE, round-robin issue
// of single read commands to the FV bank controller, paced by the bank's
// stream handshake and held off while an FV_MEM write stream is open.
module fv_req_arbiter
   import fv_req_arbiter_pkg::*;
#(
   parameter int NUM_PE = NUM_EDGE_PE,
   parameter int ADDR_W = $clog2(MAX_FV_NUM)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PE-1:0]             req_valid,
   input  logic [NUM_PE-1:0][ADDR_W-1:0] req_addr,
   output logic [NUM_PE-1:0]             req_ready,
   input  logic                          fv_wr_sos,
   input  logic                          fv_wr_eos,
   input  logic                          bank_busy,
   output FV_MEM_CNTL2FV_Bank_CNTL       FV_MEM_CNTL2FV_Bank_CNTL_out,
   output logic                          idle
);

   localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   fv_state_t                     state_q, state_d;
   logic [NUM_PE-1:0]             occ_q, occ_d;
   logic [NUM_PE-1:0][ADDR_W-1:0] addr_q;
   logic                          win_q, win_d;
   FV_MEM_CNTL2FV_Bank_CNTL       out_q, out_d;

   logic [NUM_PE-1:0] capture;
   logic [NUM_PE-1:0] gnt_oh;
   logic [IDX_W-1:0]  gnt_idx;
   logic [ADDR_W-1:0] gnt_addr;
   logic              issue_go;

   assign capture = req_valid & ~occ_q;

   // Window state after this edge; eos wins so sos+eos together stay closed
   always_comb begin
      win_d = win_q;
      if (fv_wr_eos)      win_d = 1'b0;
      else if (fv_wr_sos) win_d = 1'b1;
   end

   // Issue only from IDLE with work pending and no write stream open or opening;
   // looking at win_d lets the issue follow eos by a single cycle
   always_comb begin
      issue_go = (state_q == ST_IDLE) && (|occ_q) && !fv_wr_sos && !win_d;
   end

   rr_arbiter #(
      .NUM_PE (NUM_PE)
   ) u_rr (
      .clk       (clk),
      .rst_n     (reset),
      .req_i     (occ_q),
      .gnt_en_i  (issue_go),
      .gnt_o     (gnt_oh),
      .gnt_idx_o (gnt_idx)
   );

   // One-hot mux of the winning slot address
   always_comb begin
      gnt_addr = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (gnt_oh[i]) gnt_addr = addr_q[i];
      end
   end

   // FSM: IDLE -> ISSUE -> START -> STREAM, back to IDLE on the bank's last beat
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (issue_go) state_d = ST_ISSUE;
         ST_ISSUE:  state_d = ST_START;
         ST_START:  state_d = ST_STREAM;
         ST_STREAM: if (!bank_busy) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // The command is loaded on entry to ISSUE so it is driven from flops during ISSUE
   always_comb begin
      out_d = '0;
      if (issue_go) begin
         out_d.valid        = 1'b1;
         out_d.FV_Bank_addr = FV_ADDR_W'(gnt_addr);
         out_d.PE_tag       = PE_TAG_W'(gnt_idx);
      end
   end

   // Issued slot frees on leaving ISSUE, so its ready rises in START
   always_comb begin
      occ_d = occ_q;
      if (state_q == ST_ISSUE) occ_d[out_q.PE_tag] = 1'b0;
      occ_d = occ_d | capture;
   end

   // Control state with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         occ_q   <= '0;
         win_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         win_q   <= win_d;
         out_q   <= out_d;
      end
   end

   // Slot addresses are plain data, qualified by occ_q
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PE; i++) begin
         if (capture[i]) addr_q[i] <= req_addr[i];
      end
   end

   assign req_ready                    = ~occ_q;
   assign idle                         = !(|occ_q) && (state_q == ST_IDLE) && !win_q;
   assign FV_MEM_CNTL2FV_Bank_CNTL_out = out_q;

endmodule

// File: tb/tb_fv_req_arbiter.sv
// Bench for fv_req_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_fv_req_arbiter;
   import fv_req_arbiter_pkg::*;

   localparam int NP = 4;
   localparam int AW = 8;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NP-1:0]         req_valid;
   logic [NP-1:0][AW-1:0] req_addr;
   logic [NP-1:0]         req_ready;
   logic                  fv_wr_sos, fv_wr_eos, bank_busy;
   FV_MEM_CNTL2FV_Bank_CNTL out;
   logic                  idle;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   fv_req_arbiter #(.NUM_PE(NP), .ADDR_W(AW)) dut (
      .clk                          (clk),
      .reset                        (reset),
      .req_valid                    (req_valid),
      .req_addr                     (req_addr),
      .req_ready                    (req_ready),
      .fv_wr_sos                    (fv_wr_sos),
      .fv_wr_eos                    (fv_wr_eos),
      .bank_busy                    (bank_busy),
      .FV_MEM_CNTL2FV_Bank_CNTL_out (out),
      .idle                         (idle)
   );

   // Behavioural model. m_phase: 0 waiting, 1 command out, 2 bank entering
   // stream, 3 bank streaming (m_scnt beats so far).
   bit [NP-1:0] m_occ;
   logic [AW-1:0] m_addr [NP];
   int          m_last;
   bit          m_win;
   int          m_phase;
   int          m_scnt;
   int          m_tag;
   logic [AW-1:0] m_vaddr;
   int          bb_len = 1;

   function automatic void model_reset();
      m_occ   = '0;
      m_last  = NP - 1;
      m_win   = 1'b0;
      m_phase = 0;
      m_scnt  = 0;
      m_tag   = 0;
      m_vaddr = '0;
   endfunction

   function automatic void model_edge();
      bit          win_n;
      bit [NP-1:0] cap;
      win_n = fv_wr_eos ? 1'b0 : (fv_wr_sos ? 1'b1 : m_win);
      cap   = req_valid & ~m_occ;
      case (m_phase)
         1: begin m_occ[m_tag] = 1'b0; m_phase = 2; end
         2: begin m_phase = 3; m_scnt = 0; end
         3: if (!bank_busy) m_phase = 0; else m_scnt++;
         default: if ((m_occ != 0) && !fv_wr_sos && !win_n) begin
            for (int k = 1; k <= NP; k++) begin
               int c;
               c = (m_last + k) % NP;
               if (m_occ[c]) begin
                  m_tag = c; m_vaddr = m_addr[c]; m_last = c; m_phase = 1;
                  break;
               end
            end
         end
      endcase
      for (int i = 0; i < NP; i++) if (cap[i]) begin m_occ[i] = 1'b1; m_addr[i] = req_addr[i]; end
      m_win = win_n;
   endfunction

   // Bank drives busy low on the last stream beat; then one clock edge
   task automatic tick();
      bank_busy = !(m_phase == 3 && m_scnt >= bb_len - 1);
      @(posedge clk);
      if (!reset) model_reset(); else model_edge();
      cyc++;
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = '0; fv_wr_sos = 1'b0; fv_wr_eos = 1'b0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset = 1'b0;
      model_reset();
      repeat (2) tick();
      reset = 1'b1;
   endtask

   task automatic drain();
      clear_inputs();
      for (int k = 0; k < 200 && idle !== 1'b1; k++) tick();
   endtask

   task automatic test_reset();
      req_valid = 4'b0001; req_addr[0] = 8'h11;
      reset = 1'b0; model_reset();
      repeat (2) tick();
      checks++; if (req_ready !== 4'hF) begin errors++; $display("FAIL reset_ready: got %b want 1111", req_ready); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
      checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", out); end
      reset = 1'b1;
      tick();
      req_valid = '0;
      checks++; if (out.valid !== 1'b0) begin errors++; $display("FAIL reset_first_edge: valid=%b want 0", out.valid); end
      checks++; if (req_ready !== 4'b1110) begin errors++; $display("FAIL reset_capture: ready=%b want 1110", req_ready); end
      tick();
      checks++; if (out.valid !== 1'b1 || out.PE_tag !== 2'd0 || out.FV_Bank_addr !== 8'h11) begin
         errors++; $display("FAIL reset_second_edge: got %h want valid tag0 addr11", out); end
      drain();
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_drain: idle=%b want 1", idle); end
   endtask

   task automatic test_single();
      bb_len = 2;
      req_addr[2] = 8'h05; req_valid = 4'b0100;
      tick();
      req_valid = '0;
      checks++; if (out.valid !== 1'b0 || req_ready[2] !== 1'b0) begin
         errors++; $display("FAIL single_latency: valid=%b ready2=%b want 0 0", out.valid, req_ready[2]); end
      tick();
      checks++; if (out.valid !== 1'b1 || out.FV_Bank_addr !== 8'h05 || out.PE_tag !== 2'd2) begin
         errors++; $display("FAIL single_issue: got %h want valid addr05 tag2", out); end
      checks++; if (req_ready[2] !== 1'b0) begin errors++; $display("FAIL single_ready_issue: got %b want 0", req_ready[2]); end
      tick();
      checks++; if (req_ready[2] !== 1'b1) begin errors++; $display("FAIL single_ready_after: got %b want 1", req_ready[2]); end
      checks++; if (out !== '0) begin errors++; $display("FAIL single_out_zero: got %h want 0", out); end
      drain();
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_drain: idle=%b want 1", idle); end
   endtask

   task automatic test_all_four();
      int tags[$]; int cycs[$]; logic [AW-1:0] addrs[$];
      apply_reset();
      bb_len = 3;
      for (int i = 0; i < NP; i++) req_addr[i] = AW'(8'h10 * (i + 1));
      req_valid = 4'hF;
      tick();
      req_valid = '0;
      for (int k = 0; k < 80 && tags.size() < 4; k++) begin
         if (out.valid === 1'b1) begin tags.push_back(int'(out.PE_tag)); cycs.push_back(cyc); addrs.push_back(out.FV_Bank_addr); end
         tick();
      end
      checks++; if (tags.size() != 4) begin errors++; $display("FAIL all4_count: got %0d want 4", tags.size()); end
      for (int k = 0; k < tags.size(); k++) begin
         checks++; if (tags[k] != k || addrs[k] !== AW'(8'h10 * (k + 1))) begin
            errors++; $display("FAIL all4_order[%0d]: tag %0d addr %h want tag %0d addr %h", k, tags[k], addrs[k], k, AW'(8'h10 * (k + 1))); end
         if (k > 0) begin
            checks++; if (cycs[k] - cycs[k-1] != 6) begin
               errors++; $display("FAIL all4_gap[%0d]: got %0d want 6", k, cycs[k] - cycs[k-1]); end
         end
      end
      drain();
   endtask

   task automatic test_write_window();
      apply_reset();
      bb_len = 2;
      req_addr[1] = 8'h21; req_valid = 4'b0010; fv_wr_sos = 1'b1;
      tick();
      req_valid = '0; fv_wr_sos = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++; if (out.valid !== 1'b0 || idle !== 1'b0) begin
            errors++; $display("FAIL window_block[%0d]: valid=%b idle=%b want 0 0", k, out.valid, idle); end
         tick();
      end
      fv_wr_eos = 1'b1;
      checks++; if (out.valid !== 1'b0) begin errors++; $display("FAIL window_eos_cycle: valid=%b want 0", out.valid); end
      tick();
      fv_wr_eos = 1'b0;
      checks++; if (out.valid !== 1'b1 || out.PE_tag !== 2'd1 || out.FV_Bank_addr !== 8'h21) begin
         errors++; $display("FAIL window_release: got %h want valid addr21 tag1", out); end
      drain();
   endtask

   task automatic test_fast_stream();
      int tags[$]; int cycs[$];
      apply_reset();
      bb_len = 1;
      req_addr[0] = 8'hA0; req_addr[3] = 8'hA3; req_valid = 4'b1001;
      tick();
      req_valid = '0;
      for (int k = 0; k < 40 && tags.size() < 2; k++) begin
         if (out.valid === 1'b1) begin tags.push_back(int'(out.PE_tag)); cycs.push_back(cyc); end
         tick();
      end
      checks++; if (tags.size() != 2) begin errors++; $display("FAIL fast_count: got %0d want 2", tags.size()); end
      else begin
         checks++; if (tags[0] != 0 || tags[1] != 3) begin errors++; $display("FAIL fast_order: got %0d,%0d want 0,3", tags[0], tags[1]); end
         checks++; if (cycs[1] - cycs[0] != 4) begin errors++; $display("FAIL fast_gap: got %0d want 4", cycs[1] - cycs[0]); end
      end
      drain();
   endtask

   task automatic test_reset_mid_stream();
      apply_reset();
      bb_len = 20;
      req_addr[1] = 8'h31; req_valid = 4'b0010;
      tick();
      req_valid = '0;
      repeat (3) tick();
      req_addr[0] = 8'h30; req_addr[3] = 8'h33; req_valid = 4'b1001;
      tick();
      req_valid = '0;
      checks++; if (req_ready !== 4'b0110) begin errors++; $display("FAIL midrst_pending: ready=%b want 0110", req_ready); end
      reset = 1'b0; model_reset();
      #1;
      checks++; if (req_ready !== 4'hF || idle !== 1'b1 || out !== '0) begin
         errors++; $display("FAIL midrst_async: ready=%b idle=%b out=%h want 1111 1 0", req_ready, idle, out); end
      tick();
      reset = 1'b1;
      for (int k = 0; k < 20; k++) begin
         checks++; if (out.valid !== 1'b0) begin errors++; $display("FAIL midrst_replay[%0d]: valid=%b want 0", k, out.valid); end
         tick();
      end
      checks++; if (req_ready !== 4'hF || idle !== 1'b1) begin
         errors++; $display("FAIL midrst_final: ready=%b idle=%b want 1111 1", req_ready, idle); end
   endtask

   task automatic test_rerequest();
      int tags[$];
      apply_reset();
      bb_len = 1;
      req_addr[0] = 8'h40; req_addr[1] = 8'h41; req_valid = 4'b0011;
      for (int k = 0; k < 100 && tags.size() < 6; k++) begin
         if (out.valid === 1'b1) tags.push_back(int'(out.PE_tag));
         tick();
      end
      checks++; if (tags.size() != 6) begin errors++; $display("FAIL rereq_count: got %0d want 6", tags.size()); end
      for (int k = 0; k < tags.size(); k++) begin
         checks++; if (tags[k] != k % 2) begin errors++; $display("FAIL rereq_tag[%0d]: got %0d want %0d", k, tags[k], k % 2); end
      end
      drain();
   endtask

   task automatic test_random();
      FV_MEM_CNTL2FV_Bank_CNTL e;
      for (int n = 0; n < 400; n++) begin
         e = '0;
         if (m_phase == 1) begin e.valid = 1'b1; e.FV_Bank_addr = m_vaddr; e.PE_tag = PE_TAG_W'(m_tag); end
         checks++; if (out !== e) begin errors++; $display("FAIL rand_out@%0d: got %h want %h", cyc, out, e); end
         checks++; if (req_ready !== ~m_occ) begin errors++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, req_ready, ~m_occ); end
         checks++; if (idle !== ((m_occ == 0) && m_phase == 0 && !m_win)) begin
            errors++; $display("FAIL rand_idle@%0d: got %b want %b", cyc, idle, (m_occ == 0) && m_phase == 0 && !m_win); end
         req_valid = NP'($urandom_range(0, 15));
         for (int i = 0; i < NP; i++) req_addr[i] = AW'($urandom);
         fv_wr_sos = ($urandom_range(0, 24) == 0);
         fv_wr_eos = ($urandom_range(0, 7) == 0);
         if (m_phase != 3) bb_len = $urandom_range(1, 4);
         tick();
      end
      drain();
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rand_drain: idle=%b want 1", idle); end
   endtask

   initial begin
      reset = 1'b0; bank_busy = 1'b1; req_addr = '0;
      clear_inputs();
      model_reset();
      test_reset();
      test_single();
      test_all_four();
      test_write_window();
      test_fast_stream();
      test_reset_mid_stream();
      test_rerequest();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
